// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between an instruction-fetch requester and
// a data requester. Data normally wins, but an instruction request is forced
// through after STARVE_MAX consecutive data grants made while it was waiting.
//
// Ports:
//   CLK, RST            clock and synchronous active-high reset
//   iREN, iaddr         instruction fetch request and word address
//   dREN, dWEN          data read / write request (write wins if both are high)
//   daddr, dstore       data address and store data
//   ihit, iload         one-cycle instruction completion pulse, fetched word
//   dhit, dload         one-cycle data completion pulse, loaded word
//   ramREN, ramWEN      RAM read / write strobes
//   ramaddr, ramstore   RAM address and write data
//   ramload             RAM read data
//   ramstate            RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   memerr              sticky flag, set by any RAM ERROR, cleared only by reset
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DBUS = 3'd1;
  localparam logic [2:0] IBUS = 3'd2;
  localparam logic [2:0] DHIT = 3'd3;
  localparam logic [2:0] IHIT = 3'd4;

  localparam logic [1:0] R_FREE   = 2'd0;
  localparam logic [1:0] R_BUSY   = 2'd1;
  localparam logic [1:0] R_ACCESS = 2'd2;
  localparam logic [1:0] R_ERROR  = 2'd3;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0]  state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] dstore_q, dstore_d;
  logic        dwr_q, dwr_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic        memerr_q, memerr_d;
  logic        ihit_q, ihit_d;
  logic        dhit_q, dhit_d;
  logic        ramren_q, ramren_d;
  logic        ramwen_q, ramwen_d;
  logic [31:0] ramaddr_q, ramaddr_d;
  logic [31:0] ramstore_q, ramstore_d;

  // Next-state, request latching, starvation counting and RAM result capture.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    daddr_d  = daddr_q;
    dstore_d = dstore_q;
    dwr_d    = dwr_q;
    iaddr_d  = iaddr_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    memerr_d = memerr_q;
    case (state_q)
      IDLE: begin
        if (iREN && (starve_q == STARVE_LIM)) begin
          // instruction side has waited long enough: force it through
          state_d  = IBUS;
          iaddr_d  = iaddr;
          starve_d = 3'd0;
        end else if (dREN || dWEN) begin
          state_d  = DBUS;
          daddr_d  = daddr;
          dstore_d = dstore;
          dwr_d    = dWEN;
          if (iREN) begin
            starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 3'd1;
          end else begin
            starve_d = 3'd0;
          end
        end else if (iREN) begin
          state_d  = IBUS;
          iaddr_d  = iaddr;
          starve_d = 3'd0;
        end else begin
          starve_d = 3'd0;
        end
      end
      DBUS: begin
        case (ramstate)
          R_ACCESS: begin
            if (!dwr_q) begin
              dload_d = ramload;
            end else begin
              dload_d = dload_q;
            end
            state_d = DHIT;
          end
          R_ERROR: begin
            memerr_d = 1'b1;
            state_d  = IDLE;
          end
          R_FREE, R_BUSY: state_d = DBUS;
          default:        state_d = DBUS;
        endcase
      end
      IBUS: begin
        case (ramstate)
          R_ACCESS: begin
            iload_d = ramload;
            state_d = IHIT;
          end
          R_ERROR: begin
            memerr_d = 1'b1;
            state_d  = IDLE;
          end
          R_FREE, R_BUSY: state_d = IBUS;
          default:        state_d = IBUS;
        endcase
      end
      DHIT:    state_d = IDLE;
      IHIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    ihit_d     = (state_d == IHIT);
    dhit_d     = (state_d == DHIT);
    ramren_d   = (state_d == IBUS) || ((state_d == DBUS) && !dwr_d);
    ramwen_d   = (state_d == DBUS) && dwr_d;
    if (state_d == DBUS) begin
      ramaddr_d  = daddr_d;
      ramstore_d = dstore_d;
    end else if (state_d == IBUS) begin
      ramaddr_d  = iaddr_d;
      ramstore_d = 32'd0;
    end else begin
      ramaddr_d  = 32'd0;
      ramstore_d = 32'd0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      starve_q   <= 3'd0;
      daddr_q    <= 32'd0;
      dstore_q   <= 32'd0;
      dwr_q      <= 1'b0;
      iaddr_q    <= 32'd0;
      iload_q    <= 32'd0;
      dload_q    <= 32'd0;
      memerr_q   <= 1'b0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= 32'd0;
      ramstore_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      daddr_q    <= daddr_d;
      dstore_q   <= dstore_d;
      dwr_q      <= dwr_d;
      iaddr_q    <= iaddr_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      memerr_q   <= memerr_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      ramren_q   <= ramren_d;
      ramwen_q   <= ramwen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
    end
  end

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign memerr   = memerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with explicit expected
// values, then randomized traffic, all checked cycle by cycle against a
// transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int SMAX = 4;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = 32'd0, daddr = 32'd0, dstore = 32'd0, ramload = 32'd0;
  logic [1:0]  ramstate = 2'd0;
  logic        ihit, dhit, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload), .dhit(dhit),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, who is owed a hit, latched request.
  bit          m_bus_d, m_bus_i, m_hit_d, m_hit_i, m_wr, m_err;
  logic [31:0] m_daddr, m_dstore, m_iaddr, m_iload, m_dload;
  int          m_starve;

  task automatic model_edge();
    bit want_d;
    want_d = dREN | dWEN;
    if (RST) begin
      {m_bus_d, m_bus_i, m_hit_d, m_hit_i, m_wr, m_err} = 6'b0;
      m_daddr = 0; m_dstore = 0; m_iaddr = 0; m_iload = 0; m_dload = 0; m_starve = 0;
    end else if (m_hit_d || m_hit_i) begin
      m_hit_d = 0; m_hit_i = 0;
    end else if (m_bus_d || m_bus_i) begin
      if (ramstate == ACCESS) begin
        if (m_bus_d) begin
          if (!m_wr) m_dload = ramload;
          m_hit_d = 1;
        end else begin
          m_iload = ramload;
          m_hit_i = 1;
        end
        m_bus_d = 0; m_bus_i = 0;
      end else if (ramstate == ERROR) begin
        m_err = 1; m_bus_d = 0; m_bus_i = 0;
      end
    end else begin
      if (iREN && (m_starve == SMAX || !want_d)) begin
        m_bus_i = 1; m_iaddr = iaddr; m_starve = 0;
      end else if (want_d) begin
        m_bus_d = 1; m_wr = dWEN; m_daddr = daddr; m_dstore = dstore;
        m_starve = iREN ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
      end else begin
        m_starve = 0;
      end
    end
  endtask

  // Directed-mode helpers: automatic RAM responder and requester drop-off.
  bit          auto_mode = 0, ram_err = 0;
  int          ram_wait = 0, d_left = 0, i_left = 0, bus_n = 0;
  int          n_ihit, n_dhit, n_ren, grant_n;
  logic [31:0] grant_bits, wstore_seen;

  task automatic clear_stats();
    n_ihit = 0; n_dhit = 0; n_ren = 0; grant_n = 0; grant_bits = 0; wstore_seen = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_eq("ihit", ihit, m_hit_i);
    check_eq("dhit", dhit, m_hit_d);
    check_eq("ramREN", ramREN, m_bus_i | (m_bus_d & !m_wr));
    check_eq("ramWEN", ramWEN, m_bus_d & m_wr);
    check_eq("ramaddr", ramaddr, m_bus_d ? m_daddr : (m_bus_i ? m_iaddr : 32'd0));
    check_eq("ramstore", ramstore, m_bus_d ? m_dstore : 32'd0);
    check_eq("iload", iload, m_iload);
    check_eq("dload", dload, m_dload);
    check_eq("memerr", memerr, m_err);
    if (ihit) n_ihit++;
    if (dhit) n_dhit++;
    if (ramREN) n_ren++;
    if (ramWEN) wstore_seen = ramstore;
    if (ramREN || ramWEN) begin
      bus_n++;
      if (bus_n == 1) begin
        grant_bits = (grant_bits << 1) | {31'd0, (ramREN && !ramWEN && ramaddr == iaddr)};
        grant_n++;
      end
    end else begin
      bus_n = 0;
    end
    if (auto_mode) begin
      if (!(ramREN || ramWEN)) ramstate = FREE;
      else if (ram_err) ramstate = ERROR;
      else ramstate = (bus_n > ram_wait) ? ACCESS : BUSY;
      if (dhit && d_left > 0) begin
        d_left--;
        if (d_left == 0) begin dREN = 0; dWEN = 0; end
      end
      if (ihit && i_left > 0) begin
        i_left--;
        if (i_left == 0) iREN = 0;
      end
    end
  endtask

  initial begin
    int r;
    // Reset
    RST = 1; step(); step();
    check_eq("rst_strobes", {27'd0, ramREN, ramWEN, ihit, dhit, memerr}, 32'd0);
    check_eq("rst_addr", ramaddr | ramstore | iload | dload, 32'd0);
    RST = 0; step();

    // Instruction read with two BUSY cycles
    auto_mode = 1; clear_stats();
    ram_wait = 2; ram_err = 0; ramload = 32'h2401_0005;
    iaddr = 32'h0000_0040; iREN = 1; i_left = 1;
    repeat (10) step();
    check_eq("ifetch_ren_cycles", n_ren, 3);
    check_eq("ifetch_ihit_count", n_ihit, 1);
    check_eq("ifetch_iload", iload, 32'h2401_0005);

    // Simultaneous requests: data first, then instruction
    clear_stats(); ram_wait = 0; ramload = 32'hDEAD_BEEF;
    daddr = 32'h0000_0100; dREN = 1; d_left = 1; iREN = 1; i_left = 1;
    repeat (12) step();
    check_eq("simul_grants", grant_n, 2);
    check_eq("simul_order", grant_bits, 32'b01);
    check_eq("simul_dload", dload, 32'hDEAD_BEEF);
    check_eq("simul_hits", {n_dhit[15:0], n_ihit[15:0]}, {16'd1, 16'd1});

    // Write leaves dload untouched
    clear_stats(); ram_wait = 1; ramload = 32'h55AA_55AA;
    daddr = 32'h0000_0200; dstore = 32'h1234_5678; dWEN = 1; d_left = 1;
    repeat (8) step();
    check_eq("write_store", wstore_seen, 32'h1234_5678);
    check_eq("write_dhit", n_dhit, 1);
    check_eq("write_dload", dload, 32'hDEAD_BEEF);

    // Starvation: four data grants, forced instruction grant, fifth data grant
    clear_stats(); ram_wait = 0; ramload = 32'h0BAD_F00D;
    daddr = 32'h0000_0300; dREN = 1; d_left = 5; iaddr = 32'h0000_0040; iREN = 1; i_left = 1;
    repeat (30) step();
    check_eq("starve_grants", grant_n, 6);
    check_eq("starve_order", grant_bits, 32'b000010);
    check_eq("starve_hits", {n_dhit[15:0], n_ihit[15:0]}, {16'd5, 16'd1});

    // RAM error during an instruction fetch
    clear_stats(); ram_err = 1; iaddr = 32'h0000_0080; iREN = 1; i_left = 0;
    step();
    iREN = 0;
    repeat (5) step();
    check_eq("err_memerr", memerr, 1);
    check_eq("err_no_ihit", n_ihit, 0);
    check_eq("err_idle", {31'd0, ramREN}, 32'd0);
    ram_err = 0;

    // Reset in the second DBUS cycle aborts the access
    auto_mode = 0; ramstate = FREE;
    RST = 1; step(); RST = 0;
    clear_stats(); ramstate = BUSY; daddr = 32'h0000_0400; dREN = 1;
    step();
    dREN = 0;
    step();
    RST = 1; step(); RST = 0;
    check_eq("rstmid_strobes", {27'd0, ramREN, ramWEN, ihit, dhit, memerr}, 32'd0);
    check_eq("rstmid_data", ramaddr | ramstore | iload | dload, 32'd0);
    step();
    check_eq("rstmid_no_dhit", n_dhit, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RST     = ($urandom_range(0, 63) == 0);
      iREN    = ($urandom_range(0, 9) < 6);
      dREN    = $urandom_range(0, 1);
      dWEN    = ($urandom_range(0, 3) == 0);
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      r = $urandom_range(0, 99);
      ramstate = (r < 30) ? FREE : (r < 60) ? BUSY : (r < 97) ? ACCESS : ERROR;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
